// File: rtl/collapse_key_reader.sv
// Reader-side sequencer for an array of read-once collapse cells: strobes each cell once, assembles the key.
// Optional macro COLLAPSE_READER_KILL_ON_ERR_EN adds a KILL state that fuses the unread cells after a bad fragment.
module collapse_key_reader #(
  parameter int NUM_CELLS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  output logic [NUM_CELLS-1:0]   cell_read,
  input  logic [8*NUM_CELLS-1:0] cell_key,
  input  logic [NUM_CELLS-1:0]   cell_oe,
  input  logic [NUM_CELLS-1:0]   cell_pad,
  output logic [NUM_CELLS-1:0]   cell_fuse,
  output logic [8*NUM_CELLS-1:0] key_out,
  output logic                   key_valid,
  input  logic                   key_ack,
  output logic                   done,
  output logic                   busy,
  output logic                   err,
  output logic [3:0]             err_cell
);

  localparam logic [3:0] LAST = 4'(NUM_CELLS - 1);

`ifdef COLLAPSE_READER_KILL_ON_ERR_EN
  typedef enum logic [2:0] {S_IDLE, S_READ, S_HOLD, S_ZERO, S_FAIL, S_KILL} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_READ, S_HOLD, S_ZERO, S_FAIL} state_t;
`endif

  state_t                 state_q, state_d;
  logic [3:0]             idx_q, idx_d;
  logic [NUM_CELLS-1:0]   rd_q, rd_d;
  logic [8*NUM_CELLS-1:0] key_q, key_d;
  logic                   vld_q, vld_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic                   err_q, err_d;
  logic [3:0]             err_cell_q, err_cell_d;
`ifdef COLLAPSE_READER_KILL_ON_ERR_EN
  logic [NUM_CELLS-1:0]   fuse_q, fuse_d;
`endif

  // Fragment currently addressed by idx, selected without over-wide bit indices
  logic       frag_oe, frag_pad;
  logic [7:0] frag_byte;
  logic [3:0] idx_nxt;

  always_comb begin
    frag_oe   = 1'b0;
    frag_pad  = 1'b0;
    frag_byte = 8'h00;
    for (int k = 0; k < NUM_CELLS; k++) begin
      if (idx_q == k[3:0]) begin
        frag_oe   = cell_oe[k];
        frag_pad  = cell_pad[k];
        frag_byte = cell_key[8*k +: 8];
      end
    end
  end

  assign idx_nxt = idx_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rd_d       = '0;
    key_d      = key_q;
    vld_d      = 1'b0;
    done_d     = 1'b0;
    err_d      = err_q;
    err_cell_d = err_cell_q;
`ifdef COLLAPSE_READER_KILL_ON_ERR_EN
    fuse_d     = '0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          idx_d   = 4'd0;
          err_d   = 1'b0;
          key_d   = '0;
          rd_d[0] = 1'b1;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (abort) begin
          key_d   = '0;
          err_d   = 1'b0;
          state_d = S_IDLE;
        end else if (frag_oe && frag_pad) begin
          for (int k = 0; k < NUM_CELLS; k++) begin
            if (idx_q == k[3:0]) key_d[8*k +: 8] = frag_byte;
          end
          if (idx_q == LAST) begin
            vld_d   = 1'b1;
            state_d = S_HOLD;
          end else begin
            idx_d = idx_nxt;
            for (int k = 0; k < NUM_CELLS; k++) rd_d[k] = (idx_nxt == k[3:0]);
          end
        end else begin
          // Bad fragment: its byte is dropped and the partial key destroyed
          key_d      = '0;
          err_cell_d = idx_q;
`ifdef COLLAPSE_READER_KILL_ON_ERR_EN
          for (int k = 0; k < NUM_CELLS; k++) fuse_d[k] = (k[3:0] >= idx_q);
          state_d = S_KILL;
`else
          err_d   = 1'b1;
          state_d = S_FAIL;
`endif
        end
      end
      S_HOLD: begin
        if (abort) begin
          key_d   = '0;
          err_d   = 1'b0;
          state_d = S_IDLE;
        end else if (key_ack) begin
          key_d   = '0;
          done_d  = 1'b1;
          state_d = S_ZERO;
        end else begin
          vld_d = 1'b1;
        end
      end
      S_ZERO: begin
        key_d   = '0;
        state_d = S_IDLE;
      end
      S_FAIL: begin
        key_d = '0;
        if (abort) begin
          err_d   = 1'b0;
          state_d = S_IDLE;
        end else if (start) begin
          idx_d   = 4'd0;
          err_d   = 1'b0;
          rd_d[0] = 1'b1;
          state_d = S_READ;
        end
      end
`ifdef COLLAPSE_READER_KILL_ON_ERR_EN
      S_KILL: begin
        key_d   = '0;
        err_d   = 1'b1;
        state_d = S_FAIL;
      end
`endif
      default: begin
        key_d   = '0;
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE) && (state_d != S_FAIL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= 4'd0;
      rd_q       <= '0;
      key_q      <= '0;
      vld_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      err_cell_q <= 4'd0;
`ifdef COLLAPSE_READER_KILL_ON_ERR_EN
      fuse_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rd_q       <= rd_d;
      key_q      <= key_d;
      vld_q      <= vld_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      err_cell_q <= err_cell_d;
`ifdef COLLAPSE_READER_KILL_ON_ERR_EN
      fuse_q     <= fuse_d;
`endif
    end
  end

  // An abort in the strobe cycle must keep the cell from being consumed
  assign cell_read = rd_q & ~{NUM_CELLS{abort}};
  assign key_out   = key_q & {(8*NUM_CELLS){vld_q}};
  assign key_valid = vld_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign err_cell  = err_cell_q;
`ifdef COLLAPSE_READER_KILL_ON_ERR_EN
  assign cell_fuse = fuse_q;
`else
  assign cell_fuse = '0;
`endif

endmodule

// File: tb/tb_collapse_key_reader.sv
// Directed bench for collapse_key_reader (NUM_CELLS=4) with hand-computed expectations.
module tb_collapse_key_reader;

  logic        clk = 1'b0;
  logic        reset, start, abort, key_ack;
  logic [3:0]  cell_read, cell_oe, cell_pad, cell_fuse;
  logic [31:0] cell_key, key_out;
  logic        key_valid, done, busy, err;
  logic [3:0]  err_cell;

  int tests = 0;
  int fails = 0;

  collapse_key_reader #(.NUM_CELLS(4)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cell_read(cell_read), .cell_key(cell_key), .cell_oe(cell_oe), .cell_pad(cell_pad),
    .cell_fuse(cell_fuse), .key_out(key_out), .key_valid(key_valid), .key_ack(key_ack),
    .done(done), .busy(busy), .err(err), .err_cell(err_cell)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; key_ack = 1'b0;
    cell_key = 32'h44332211; cell_oe = 4'b1111; cell_pad = 4'b1111;
    repeat (2) @(negedge clk);
    chk("rst_rd", cell_read, 0);
    chk("rst_fuse", cell_fuse, 0);
    chk("rst_key", key_out, 0);
    chk("rst_vld", key_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_errcell", err_cell, 0);
    reset = 1'b0;
    @(negedge clk);

    // Normal collection
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t1_rd", cell_read, 64'(1) << k);
      chk("t1_vld_low", key_valid, 0);
      chk("t1_busy", busy, 1);
      tick();
    end
    chk("t1_vld", key_valid, 1);
    chk("t1_key", key_out, 32'h44332211);
    chk("t1_rd_hold", cell_read, 0);
    key_ack = 1'b1; tick(); key_ack = 1'b0;
    chk("t1_done", done, 1);
    chk("t1_vld_ack", key_valid, 0);
    chk("t1_key_ack", key_out, 0);
    chk("t1_busy_zero", busy, 1);
    tick();
    chk("t1_done_end", done, 0);
    chk("t1_idle", busy, 0);

    // Cell 2 already collapsed
    cell_key = 32'h445A2211; cell_oe = 4'b1011;
    start = 1'b1; tick(); start = 1'b0;
    chk("t2_rd0", cell_read, 4'b0001); tick();
    chk("t2_rd1", cell_read, 4'b0010); tick();
    chk("t2_rd2", cell_read, 4'b0100); tick();
`ifdef COLLAPSE_READER_KILL_ON_ERR_EN
    chk("t2_fuse", cell_fuse, 4'b1100);
    chk("t2_err_kill", err, 0);
    chk("t2_busy_kill", busy, 1);
    tick();
`endif
    chk("t2_err", err, 1);
    chk("t2_errcell", err_cell, 2);
    chk("t2_key", key_out, 0);
    chk("t2_busy", busy, 0);
    chk("t2_fuse_off", cell_fuse, 0);
    for (int k = 0; k < 3; k++) begin
      chk("t2_no_rd", cell_read, 0);
      tick();
    end
    chk("t2_err_sticky", err, 1);

    // Cell 1 logically enabled but pad disabled; restart straight from FAIL
    cell_key = 32'h44332211; cell_oe = 4'b1111; cell_pad = 4'b1101;
    start = 1'b1; tick(); start = 1'b0;
    chk("t3_err_clr", err, 0);
    chk("t3_rd0", cell_read, 4'b0001); tick();
    chk("t3_rd1", cell_read, 4'b0010);
    chk("t3_key_mid", key_out, 0); tick();
`ifdef COLLAPSE_READER_KILL_ON_ERR_EN
    chk("t3_fuse", cell_fuse, 4'b1110);
    tick();
`endif
    chk("t3_err", err, 1);
    chk("t3_errcell", err_cell, 1);
    chk("t3_key", key_out, 0);
    chk("t3_no_rd", cell_read, 0);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t3_abort_err", err, 0);
    chk("t3_abort_busy", busy, 0);

    // Abort during the cycle-3 strobe, then a full run with HOLD corner cases
    cell_pad = 4'b1111;
    start = 1'b1; tick(); start = 1'b0;
    chk("t4_rd0", cell_read, 4'b0001); tick();
    chk("t4_rd1", cell_read, 4'b0010); tick();
    abort = 1'b1; #1;
    chk("t4_rd_supp", cell_read, 0);
    tick(); abort = 1'b0;
    chk("t4_busy", busy, 0);
    chk("t4_key", key_out, 0);
    chk("t4_err", err, 0);
    chk("t4_rd_idle", cell_read, 0);
    start = 1'b1; tick(); start = 1'b0;
    chk("t4_restart_rd0", cell_read, 4'b0001);
    repeat (4) tick();
    chk("t4_vld", key_valid, 1);
    chk("t4_keyv", key_out, 32'h44332211);
    start = 1'b1; tick(); start = 1'b0;
    chk("t4_start_ign_vld", key_valid, 1);
    chk("t4_start_ign_rd", cell_read, 0);
    chk("t4_start_ign_key", key_out, 32'h44332211);
    key_ack = 1'b1; abort = 1'b1; tick(); key_ack = 1'b0; abort = 1'b0;
    chk("t4_ackab_done", done, 0);
    chk("t4_ackab_vld", key_valid, 0);
    chk("t4_ackab_key", key_out, 0);
    chk("t4_ackab_idle", busy, 0);

    // Asynchronous reset mid-collection
    start = 1'b1; tick(); start = 1'b0;
    tick();
    chk("t5_rd1", cell_read, 4'b0010);
    reset = 1'b1; #1;
    chk("t5_rd", cell_read, 0);
    chk("t5_key", key_out, 0);
    chk("t5_busy", busy, 0);
    chk("t5_vld", key_valid, 0);
    chk("t5_err", err, 0);
    tick(); reset = 1'b0;
    tick();
    chk("t5_idle_rd", cell_read, 0);
    chk("t5_idle_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
